// File: rtl/sync_arith_unit_seq_if.sv
// Issue/result bundle between the operand-issuing controller and sync_arith_unit_seq.
// The controller holds the master side; the arithmetic unit holds the slave side.
interface sync_arith_unit_seq_if #(
    parameter int M = 32
);
    logic         i_valid;
    logic         o_ready;
    logic [M-1:0] iarg_A;
    logic [M-1:0] iarg_B;
    logic [3:0]   iop;
    logic [M-1:0] o_result;
    logic [3:0]   o_status;
    logic         o_valid;

    modport master (
        output i_valid, iarg_A, iarg_B, iop,
        input  o_ready, o_result, o_status, o_valid
    );

    modport slave (
        input  i_valid, iarg_A, iarg_B, iop,
        output o_ready, o_result, o_status, o_valid
    );
endinterface

// File: rtl/sync_arith_unit_seq.sv
// Handshaked shift / compare / signed-divide / sign-magnitude-convert unit.
// Division is restoring on magnitudes, one quotient bit per cycle; sign applied in FIX.
module sync_arith_unit_seq #(
    parameter int M = 32
) (
    input  logic                 clk,
    input  logic                 i_reset,
    sync_arith_unit_seq_if.slave bus
);
    localparam int CW = $clog2(M + 1);

    typedef logic [M-1:0] word_t;
    typedef enum logic [1:0] {IDLE, EXEC, DIV, FIX} state_t;

    localparam logic [3:0] OP_SHR = 4'd0;
    localparam logic [3:0] OP_LE  = 4'd1;
    localparam logic [3:0] OP_DIV = 4'd2;
    localparam logic [3:0] OP_ZM  = 4'd3;

    localparam word_t MIN_NEG  = {1'b1, {(M-1){1'b0}}};
    localparam word_t SH_LIMIT = word_t'(M);

    state_t        state, state_nxt;
    word_t         a_r, b_r, rem, quo, dvs;
    logic [3:0]    op_r;
    logic          neg;
    logic [CW-1:0] cnt;

    logic          accept, div_legal;
    word_t         mag_a, mag_b, shamt;
    logic [M:0]    trial;
    logic          trial_ok;
    word_t         rem_nxt;

    logic          wr_en, wr_err, wr_ovf;
    word_t         wr_res;

    assign bus.o_ready = (state == IDLE) && !i_reset;
    assign accept      = bus.i_valid && bus.o_ready;

    // Zero divisor and MIN/-1 resolve in one cycle through EXEC instead of iterating.
    assign div_legal = (bus.iop == OP_DIV) && (bus.iarg_B != '0) &&
                       !((bus.iarg_A == MIN_NEG) && (bus.iarg_B == '1));

    assign mag_a = bus.iarg_A[M-1] ? -bus.iarg_A : bus.iarg_A;
    assign mag_b = bus.iarg_B[M-1] ? -bus.iarg_B : bus.iarg_B;
    assign shamt = ~b_r;

    assign trial    = {rem, quo[M-1]} - {1'b0, dvs};
    assign trial_ok = !trial[M];
    assign rem_nxt  = trial_ok ? trial[M-1:0] : {rem[M-2:0], quo[M-1]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // NOTE: each combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = div_legal ? DIV : EXEC;
            EXEC:    state_nxt = IDLE;
            DIV:     if (cnt == CW'(M - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: operand and divider registers carry no reset; accept always loads them before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r  <= bus.iarg_A;
            b_r  <= bus.iarg_B;
            op_r <= bus.iop;
            rem  <= '0;
            quo  <= mag_a;
            dvs  <= mag_b;
            neg  <= bus.iarg_A[M-1] ^ bus.iarg_B[M-1];
            cnt  <= '0;
        end else if (state == DIV) begin
            rem <= rem_nxt;
            quo <= {quo[M-2:0], trial_ok};
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        wr_en  = 1'b0;
        wr_res = '0;
        wr_err = 1'b0;
        wr_ovf = 1'b0;
        if (state == EXEC) begin
            wr_en = 1'b1;
            unique case (op_r)
                OP_SHR: begin
                    if (shamt >= SH_LIMIT) wr_ovf = 1'b1;
                    else                   wr_res = a_r >> shamt;
                end
                OP_LE:  wr_res = (a_r <= shamt) ? '1 : '0;
                OP_DIV: begin
                    // Only the zero-divisor and MIN/-1 cases reach EXEC.
                    if (b_r == '0) begin
                        wr_err = 1'b1;
                    end else begin
                        wr_ovf = 1'b1;
                        wr_res = a_r;
                    end
                end
                OP_ZM:   wr_res = a_r[M-1] ? -{1'b0, a_r[M-2:0]} : a_r;
                default: wr_err = 1'b1;
            endcase
        end else if (state == FIX) begin
            wr_en  = 1'b1;
            wr_res = neg ? -quo : quo;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            bus.o_valid  <= 1'b0;
            bus.o_result <= '0;
            bus.o_status <= 4'b0000;
        end else begin
            bus.o_valid <= wr_en;
            if (wr_en) begin
                bus.o_result <= wr_res;
                bus.o_status <= {wr_err, ^wr_res, (wr_res == '0), wr_ovf};
            end
        end
    end
endmodule
